// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between an upstream requester and the serial adder.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );
endinterface

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Single combinational full-adder cell, reused every RUN cycle.
module serial_adder_ctrl_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_b & i_cin) | (i_a & i_cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over WIDTH cycles.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_s_next;

  serial_adder_ctrl_fa_cell u_fa (
    .i_a     (r_a_sh[0]),
    .i_b     (r_b_sh[0]),
    .i_cin   (r_carry),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the sum sits at bit 0.
  assign w_s_next = (r_s_sh >> 1) | {w_fa_sum, {(WIDTH - 1){1'b0}}};

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_d = S_RUN;
      S_RUN:   if (r_count == LAST) w_state_d = S_DONE;
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a_in;
            r_b_sh  <= bus.b_in;
            r_carry <= bus.cin_in;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_s_sh  <= w_s_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_fa_carry;
          if (r_count == LAST) begin
            r_sum  <= w_s_next;
            r_cout <= w_fa_carry;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum_out  = r_sum;
  assign bus.cout_out = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(3)) bus3 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    if (w == 8) begin
      bus8.start = st; bus8.a_in = a; bus8.b_in = b; bus8.cin_in = c;
    end else begin
      bus3.start = st; bus3.a_in = a[2:0]; bus3.b_in = b[2:0]; bus3.cin_in = c;
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done,
                        output logic [7:0] sum, output logic cout);
    if (w == 8) begin
      busy = bus8.busy; done = bus8.done; sum = bus8.sum_out; cout = bus8.cout_out;
    end else begin
      busy = bus3.busy; done = bus3.done; sum = {5'b0, bus3.sum_out}; cout = bus3.cout_out;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // inj1/inj2: sample indices at which a stray start with other operands is driven.
  task automatic run_op(input int w, input logic [7:0] a_raw, input logic [7:0] b_raw,
                        input logic c, input int inj1, input int inj2);
    logic [7:0] mask, a, b, sum, e_sum;
    logic [8:0] e;
    logic       busy, done, cout, e_cout;
    int         n, nbusy, ndone;
    mask   = (w == 8) ? 8'hFF : 8'h07;
    a      = a_raw & mask;
    b      = b_raw & mask;
    e      = 9'(a) + 9'(b) + 9'(c);
    e_sum  = e[7:0] & mask;
    e_cout = e[w];
    drive(w, 1'b1, a, b, c);
    n = 0; nbusy = 0; ndone = 0; done = 1'b0;
    while (!done && n < w + 6) begin
      @(negedge clk);
      n++;
      sample(w, busy, done, sum, cout);
      if (busy) nbusy++;
      if (n == inj1 || n == inj2) drive(w, 1'b1, ~a, 8'($urandom), ~c);
      else drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    if (done) ndone++;
    check_eq("done_latency", 64'(n), 64'(w + 1));
    check_eq("busy_cycles", 64'(nbusy), 64'(w));
    check_eq("sum", 64'(sum), 64'(e_sum));
    check_eq("cout", 64'(cout), 64'(e_cout));
    @(negedge clk);
    sample(w, busy, done, sum, cout);
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    if (done) ndone++;
    check_eq("done_count", 64'(ndone), 64'd1);
    check_eq("idle_after_busy", 64'(busy), 64'd0);
    check_eq("sum_hold", 64'(sum), 64'(e_sum));
    check_eq("cout_hold", 64'(cout), 64'(e_cout));
  endtask

  task automatic reset_mid();
    logic [7:0] sum;
    logic       busy, done, cout;
    int         ndone;
    drive(8, 1'b1, 8'h3C, 8'h55, 1'b1);
    repeat (5) begin
      @(negedge clk);
      drive(8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    sample(8, busy, done, sum, cout);
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    sample(8, busy, done, sum, cout);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      sample(8, busy, done, sum, cout);
      if (done || busy) ndone++;
    end
    check_eq("no_done_after_abort", 64'(ndone), 64'd0);
  endtask

  initial begin
    logic [7:0] sum;
    logic       busy, done, cout;
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sample(8, busy, done, sum, cout);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_sum", 64'(sum), 64'd0);
    check_eq("reset_cout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8, 8'h00, 8'h00, 1'b0, 0, 0);
    run_op(8, 8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(8, 8'h7F, 8'h01, 1'b0, 0, 0);
    run_op(8, 8'hA5, 8'h5A, 1'b1, 0, 0);
    run_op(8, 8'h12, 8'h34, 1'b0, 4, 9);
    run_op(8, 8'h7F, 8'h01, 1'b0, 0, 0);
    reset_mid();
    run_op(8, 8'hC3, 8'h3C, 1'b1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
    end

    for (int i = 0; i < 128; i++) begin
      run_op(3, 8'((i >> 4) & 7), 8'((i >> 1) & 7), i[0], 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
